// File: rtl/reg_writeback_stage_if.sv
// MEM/WB stage bus: MEM-stage results in, register-file write port and decode operands out.
interface reg_writeback_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
);
    logic              Stall;
    logic              Flush;
    logic              mem_valid;
    logic              mem_RegWrite;
    logic [4:0]        mem_WriteReg;
    logic [1:0]        mem_WbSel;
    logic [1:0]        mem_LoadSize;
    logic              mem_LoadSigned;
    logic [DATA_W-1:0] mem_AluResult;
    logic [DATA_W-1:0] mem_LoadData;
    logic [DATA_W-1:0] mem_PcPlus8;
    logic              RegWrite;
    logic [4:0]        WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [4:0]        ReadReg1;
    logic [4:0]        ReadReg2;
    logic [DATA_W-1:0] RegData1;
    logic [DATA_W-1:0] RegData2;
    logic [DATA_W-1:0] FwdData1;
    logic [DATA_W-1:0] FwdData2;
    logic [CNT_W-1:0]  WbCount;

    modport master (
        output Stall, Flush, mem_valid, mem_RegWrite, mem_WriteReg, mem_WbSel,
               mem_LoadSize, mem_LoadSigned, mem_AluResult, mem_LoadData, mem_PcPlus8,
               ReadReg1, ReadReg2, RegData1, RegData2,
        input  RegWrite, WriteReg, WriteData, FwdData1, FwdData2, WbCount
    );

    modport slave (
        input  Stall, Flush, mem_valid, mem_RegWrite, mem_WriteReg, mem_WbSel,
               mem_LoadSize, mem_LoadSigned, mem_AluResult, mem_LoadData, mem_PcPlus8,
               ReadReg1, ReadReg2, RegData1, RegData2,
        output RegWrite, WriteReg, WriteData, FwdData1, FwdData2, WbCount
    );
endinterface

// File: rtl/reg_writeback_stage.sv
// MEM/WB pipeline register and register-file writeback driver.
// Optional decode bypass of the in-flight write enabled by defining WB_BYPASS_EN.
module reg_writeback_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                  Clk,
    input  logic                  reset,
    reg_writeback_stage_if.slave  bus
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;

    logic              r_valid;
    logic              r_reg_write;
    logic [REG_W-1:0]  r_write_reg;
    logic [1:0]        r_wb_sel;
    logic [1:0]        r_load_size;
    logic              r_load_signed;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_load_data;
    logic [DATA_W-1:0] r_pc_plus8;
    logic [CNT_W-1:0]  r_wb_count;

    logic              w_capture;
    logic              w_reg_write;
    logic [1:0]        w_off;
    logic [HALF_W-1:0] w_half;
    logic [BYTE_W-1:0] w_byte;
    logic [DATA_W-1:0] w_load_val;
    logic [DATA_W-1:0] w_write_data;

    assign w_capture = !bus.Flush && !bus.Stall;

    // Stage register: Flush inserts a bubble, Stall holds, otherwise capture MEM.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_write_reg   <= '0;
            r_wb_sel      <= '0;
            r_load_size   <= '0;
            r_load_signed <= 1'b0;
            r_alu_result  <= '0;
            r_load_data   <= '0;
            r_pc_plus8    <= '0;
        end else if (bus.Flush) begin
            r_valid <= 1'b0;
        end else if (!bus.Stall) begin
            r_valid       <= bus.mem_valid;
            r_reg_write   <= bus.mem_RegWrite;
            r_write_reg   <= bus.mem_WriteReg;
            r_wb_sel      <= bus.mem_WbSel;
            r_load_size   <= bus.mem_LoadSize;
            r_load_signed <= bus.mem_LoadSigned;
            r_alu_result  <= bus.mem_AluResult;
            r_load_data   <= bus.mem_LoadData;
            r_pc_plus8    <= bus.mem_PcPlus8;
        end
    end

    // Counts only newly captured writes, so a held entry is never recounted.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_wb_count <= '0;
        end else if (w_capture && bus.mem_valid && bus.mem_RegWrite &&
                     (bus.mem_WriteReg != REG_W'(0))) begin
            r_wb_count <= r_wb_count + CNT_W'(1);
        end
    end

    // Little-endian sub-word extraction; half-word ignores off[0].
    always_comb begin
        w_off  = r_alu_result[1:0];
        w_half = w_off[1] ? r_load_data[31:16] : r_load_data[15:0];
        case (w_off)
            2'd0:    w_byte = r_load_data[7:0];
            2'd1:    w_byte = r_load_data[15:8];
            2'd2:    w_byte = r_load_data[23:16];
            default: w_byte = r_load_data[31:24];
        endcase
        case (r_load_size)
            2'b01:   w_load_val = {{(DATA_W-HALF_W){r_load_signed & w_half[HALF_W-1]}}, w_half};
            2'b10:   w_load_val = {{(DATA_W-BYTE_W){r_load_signed & w_byte[BYTE_W-1]}}, w_byte};
            default: w_load_val = r_load_data;
        endcase
    end

    always_comb begin
        case (r_wb_sel)
            2'b01:   w_write_data = w_load_val;
            2'b10:   w_write_data = r_pc_plus8;
            default: w_write_data = r_alu_result;
        endcase
    end

    assign w_reg_write   = r_valid && r_reg_write && (r_write_reg != REG_W'(0));
    assign bus.RegWrite  = w_reg_write;
    assign bus.WriteReg  = r_write_reg;
    assign bus.WriteData = w_write_data;
    assign bus.WbCount   = r_wb_count;

`ifdef WB_BYPASS_EN
    // Covers the window between the negedge register-file write and decode's read.
    assign bus.FwdData1 = (w_reg_write && (r_write_reg == bus.ReadReg1) &&
                           (bus.ReadReg1 != REG_W'(0))) ? w_write_data : bus.RegData1;
    assign bus.FwdData2 = (w_reg_write && (r_write_reg == bus.ReadReg2) &&
                           (bus.ReadReg2 != REG_W'(0))) ? w_write_data : bus.RegData2;
`else
    assign bus.FwdData1 = bus.RegData1;
    assign bus.FwdData2 = bus.RegData2;
`endif

endmodule

// File: tb/tb_reg_writeback_stage.sv
// Directed self-checking bench for reg_writeback_stage.
module tb_reg_writeback_stage;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    reg_writeback_stage_if #(.DATA_W(32), .CNT_W(32)) bus ();

    reg_writeback_stage #(.DATA_W(32), .CNT_W(32)) dut (
        .Clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [1:0] sz, input logic sgn, input logic [31:0] alu);
        bus.mem_valid      = v;
        bus.mem_RegWrite   = rw;
        bus.mem_WriteReg   = rd;
        bus.mem_WbSel      = sel;
        bus.mem_LoadSize   = sz;
        bus.mem_LoadSigned = sgn;
        bus.mem_AluResult  = alu;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        mem(1'b1, 1'b1, 5'd3, 2'b00, 2'b00, 1'b0, 32'hCAFE0001);
        bus.mem_LoadData = 32'h80FF7F01;
        bus.mem_PcPlus8  = 32'h0;
        bus.ReadReg1 = 5'd0;
        bus.ReadReg2 = 5'd0;
        bus.RegData1 = 32'h0;
        bus.RegData2 = 32'h0;

        // Reset state, with clock edges passing while reset is held
        step();
        chk("reset_regwrite",  32'(bus.RegWrite), 32'd0);
        chk("reset_writereg",  32'(bus.WriteReg), 32'd0);
        chk("reset_writedata", bus.WriteData, 32'h0);
        chk("reset_wbcount",   bus.WbCount, 32'd0);
        rst_n = 1'b1;

        // ALU write
        mem(1'b1, 1'b1, 5'd9, 2'b00, 2'b00, 1'b0, 32'h12345678);
        step();
        chk("alu_regwrite",  32'(bus.RegWrite), 32'd1);
        chk("alu_writereg",  32'(bus.WriteReg), 32'd9);
        chk("alu_writedata", bus.WriteData, 32'h12345678);
        chk("alu_wbcount",   bus.WbCount, 32'd1);

        // Write to $0 suppressed
        mem(1'b1, 1'b1, 5'd0, 2'b00, 2'b00, 1'b0, 32'hFFFFFFFF);
        step();
        chk("r0_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("r0_wbcount",  bus.WbCount, 32'd1);

        // Loads from 0x80FF7F01
        mem(1'b1, 1'b1, 5'd10, 2'b01, 2'b10, 1'b1, 32'h00001003);
        step();
        chk("lb_off3", bus.WriteData, 32'hFFFFFF80);
        mem(1'b1, 1'b1, 5'd10, 2'b01, 2'b10, 1'b0, 32'h00001002);
        step();
        chk("lbu_off2", bus.WriteData, 32'h000000FF);
        mem(1'b1, 1'b1, 5'd10, 2'b01, 2'b01, 1'b1, 32'h00001002);
        step();
        chk("lh_off2", bus.WriteData, 32'hFFFF80FF);
        mem(1'b1, 1'b1, 5'd10, 2'b01, 2'b01, 1'b0, 32'h00001001);
        step();
        chk("lhu_off1", bus.WriteData, 32'h00007F01);
        mem(1'b1, 1'b1, 5'd10, 2'b01, 2'b00, 1'b1, 32'h00001000);
        step();
        chk("lw",          bus.WriteData, 32'h80FF7F01);
        chk("load_wbcount", bus.WbCount, 32'd6);

        // Stall holds a reg-8 write for three cycles, counted once
        mem(1'b1, 1'b1, 5'd8, 2'b00, 2'b00, 1'b0, 32'hA5A5A5A5);
        step();
        chk("stall_first_count", bus.WbCount, 32'd7);
        bus.Stall = 1'b1;
        mem(1'b1, 1'b1, 5'd11, 2'b00, 2'b00, 1'b0, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_regwrite",  32'(bus.RegWrite), 32'd1);
            chk("stall_writereg",  32'(bus.WriteReg), 32'd8);
            chk("stall_writedata", bus.WriteData, 32'hA5A5A5A5);
            chk("stall_wbcount",   bus.WbCount, 32'd7);
        end

        // Flush beats Stall
        bus.Flush = 1'b1;
        step();
        chk("flush_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("flush_wbcount",  bus.WbCount, 32'd7);
        bus.Flush = 1'b0;
        bus.Stall = 1'b0;

        // Link address
        mem(1'b1, 1'b1, 5'd31, 2'b10, 2'b00, 1'b0, 32'h11111111);
        bus.mem_PcPlus8 = 32'h00400010;
        step();
        chk("link_writedata", bus.WriteData, 32'h00400010);
        chk("link_wbcount",   bus.WbCount, 32'd8);

        // Reserved WbSel behaves as ALU
        mem(1'b1, 1'b1, 5'd12, 2'b11, 2'b00, 1'b0, 32'h0BADF00D);
        step();
        chk("wbsel11_writedata", bus.WriteData, 32'h0BADF00D);

        // Invalid slot never writes or counts
        mem(1'b0, 1'b1, 5'd13, 2'b00, 2'b00, 1'b0, 32'h22222222);
        step();
        chk("invalid_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("invalid_wbcount",  bus.WbCount, 32'd9);

        // Decode bypass
        mem(1'b1, 1'b1, 5'd18, 2'b00, 2'b00, 1'b0, 32'h00000003);
        step();
        bus.ReadReg1 = 5'd18;
        bus.RegData1 = 32'h7;
        bus.ReadReg2 = 5'd5;
        bus.RegData2 = 32'h55;
        #1;
`ifdef WB_BYPASS_EN
        chk("fwd1_hit", bus.FwdData1, 32'h3);
`else
        chk("fwd1_pass", bus.FwdData1, 32'h7);
`endif
        chk("fwd2_miss", bus.FwdData2, 32'h55);
        mem(1'b1, 1'b1, 5'd0, 2'b00, 2'b00, 1'b0, 32'h00000003);
        step();
        bus.ReadReg1 = 5'd0;
        bus.RegData1 = 32'h9;
        #1;
        chk("fwd1_r0", bus.FwdData1, 32'h9);

        // Asynchronous reset mid-stall with a valid write in the stage
        mem(1'b1, 1'b1, 5'd14, 2'b00, 2'b00, 1'b0, 32'h44444444);
        step();
        chk("pre_reset_regwrite", 32'(bus.RegWrite), 32'd1);
        bus.Stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_regwrite",  32'(bus.RegWrite), 32'd0);
        chk("async_reset_writedata", bus.WriteData, 32'h0);
        chk("async_reset_wbcount",   bus.WbCount, 32'd0);
        step();
        chk("held_reset_regwrite", 32'(bus.RegWrite), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
